// File: rtl/clock_keeper.sv
// Time-of-day keeper: loads seconds-since-midnight, converts to h/m/s by repeated
// subtraction, then advances once per second. Optional alarm via `CLOCK_ALARM_EN.
module clock_keeper #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] userTime,
  input  logic        finish,
  output logic [4:0]  hours,
  output logic [5:0]  minutes,
  output logic [5:0]  seconds,
  output logic        valid,
  output logic        busy,
  output logic        sec_tick
`ifdef CLOCK_ALARM_EN
  ,
  input  logic [4:0]  alarmH,
  input  logic [5:0]  alarmM,
  output logic        alarm
`endif
);

  localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [31:0] SEC_PER_DAY = 32'd86400;
  localparam logic [31:0] SEC_TWO_DAYS = 32'd172800;
  localparam logic [16:0] SEC_PER_HOUR = 17'd3600;
  localparam logic [16:0] SEC_PER_MIN = 17'd60;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CONV_H,
    S_CONV_M,
    S_CONV_S,
    S_RUN
  } state_t;

  state_t          r_state;
  logic            r_finish_d;
  logic [16:0]     r_rem;
  logic [4:0]      r_acc_h;
  logic [5:0]      r_acc_m;
  logic [PW-1:0]   r_presc;
  logic [4:0]      r_hours;
  logic [5:0]      r_minutes;
  logic [5:0]      r_seconds;
  logic            r_valid;
  logic            r_busy;
  logic            r_sec_tick;

  logic            w_load_req;
  logic [16:0]     w_load_rem;
  logic            w_presc_tc;
  logic            w_sec_wrap;
  logic            w_min_wrap;
  logic            w_hr_wrap;
  logic [4:0]      w_nxt_h;
  logic [5:0]      w_nxt_m;
  logic [5:0]      w_nxt_s;

  assign w_load_req = finish & ~r_finish_d;
  assign w_presc_tc = (r_presc == PRESC_TC);

  // Fold values of one or two days back into a single day; anything larger is illegal -> 0.
  always_comb begin
    w_load_rem = 17'd0;
    if (userTime >= SEC_TWO_DAYS) begin
      w_load_rem = 17'd0;
    end else if (userTime >= SEC_PER_DAY) begin
      w_load_rem = 17'(userTime - SEC_PER_DAY);
    end else begin
      w_load_rem = userTime[16:0];
    end
  end

  // Time after the next one-second increment, with cascaded carries.
  assign w_sec_wrap = (r_seconds == 6'd59);
  assign w_min_wrap = (r_minutes == 6'd59);
  assign w_hr_wrap  = (r_hours == 5'd23);

  always_comb begin
    w_nxt_s = w_sec_wrap ? 6'd0 : 6'(r_seconds + 6'd1);
    w_nxt_m = r_minutes;
    w_nxt_h = r_hours;
    if (w_sec_wrap) begin
      w_nxt_m = w_min_wrap ? 6'd0 : 6'(r_minutes + 6'd1);
      if (w_min_wrap) begin
        w_nxt_h = w_hr_wrap ? 5'd0 : 5'(r_hours + 5'd1);
      end
    end
  end

`ifdef CLOCK_ALARM_EN
  logic r_alarm;
  logic w_alarm_hit;

  // Hours/minutes never exceed 23/59, so out-of-range alarm inputs cannot match.
  assign w_alarm_hit = (w_nxt_h == alarmH) && (w_nxt_m == alarmM) && (w_nxt_s == 6'd0);
  assign alarm = r_alarm;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_finish_d <= 1'b0;
      r_rem      <= 17'd0;
      r_acc_h    <= 5'd0;
      r_acc_m    <= 6'd0;
      r_presc    <= '0;
      r_hours    <= 5'd0;
      r_minutes  <= 6'd0;
      r_seconds  <= 6'd0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_sec_tick <= 1'b0;
`ifdef CLOCK_ALARM_EN
      r_alarm    <= 1'b0;
`endif
    end else begin
      r_finish_d <= finish;
      r_sec_tick <= 1'b0;
`ifdef CLOCK_ALARM_EN
      r_alarm    <= 1'b0;
`endif
      // A new load request preempts everything, including an ongoing conversion.
      if (w_load_req) begin
        r_state <= S_LOAD;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_LOAD: begin
            r_rem   <= w_load_rem;
            r_acc_h <= 5'd0;
            r_acc_m <= 6'd0;
            r_presc <= '0;
            r_state <= S_CONV_H;
          end
          S_CONV_H: begin
            if (r_rem >= SEC_PER_HOUR) begin
              r_rem   <= r_rem - SEC_PER_HOUR;
              r_acc_h <= 5'(r_acc_h + 5'd1);
            end else begin
              r_state <= S_CONV_M;
            end
          end
          S_CONV_M: begin
            if (r_rem >= SEC_PER_MIN) begin
              r_rem   <= r_rem - SEC_PER_MIN;
              r_acc_m <= 6'(r_acc_m + 6'd1);
            end else begin
              r_state <= S_CONV_S;
            end
          end
          S_CONV_S: begin
            r_hours   <= r_acc_h;
            r_minutes <= r_acc_m;
            r_seconds <= r_rem[5:0];
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_RUN;
          end
          S_RUN: begin
            if (w_presc_tc) begin
              r_presc    <= '0;
              r_sec_tick <= 1'b1;
              r_hours    <= w_nxt_h;
              r_minutes  <= w_nxt_m;
              r_seconds  <= w_nxt_s;
`ifdef CLOCK_ALARM_EN
              r_alarm    <= w_alarm_hit;
`endif
            end else begin
              r_presc <= r_presc + PW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_clock_keeper.sv
// Scoreboard bench for clock_keeper: stimulus queues expected load/tick events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_clock_keeper;

  localparam int unsigned HZ = 4;
  localparam int KIND_LOAD = 0;
  localparam int KIND_TICK = 1;

  typedef struct {
    int kind;
    int cyc;
    int h;
    int m;
    int s;
    bit al;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        finish = 1'b0;
  logic [31:0] userTime = 32'd0;
  logic [4:0]  hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic        valid;
  logic        busy;
  logic        sec_tick;
`ifdef CLOCK_ALARM_EN
  logic [4:0]  alarmH = 5'd7;
  logic [5:0]  alarmM = 6'd0;
  logic        alarm;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  logic busy_q = 1'b0;

  clock_keeper #(.CLK_HZ(HZ)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .userTime (userTime),
    .finish   (finish),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .valid    (valid),
    .busy     (busy),
    .sec_tick (sec_tick)
`ifdef CLOCK_ALARM_EN
    ,
    .alarmH   (alarmH),
    .alarmM   (alarmM),
    .alarm    (alarm)
`endif
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int h, input int m, input int s,
                      input bit al);
    exp_t e;
    e.kind = kind; e.cyc = c; e.h = h; e.m = m; e.s = s; e.al = al;
    sb.push_back(e);
  endtask

  // Monitor: a busy fall is a completed load, a sec_tick is an increment.
  always @(negedge CLK) begin
    exp_t e;
    int   kind;
    bit   al_bad;
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_event kind=%0d due cyc=%0d now=%0d", sb[0].kind, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if ((busy_q && !busy) || sec_tick) begin
      kind = sec_tick ? KIND_TICK : KIND_LOAD;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind=%0d cyc=%0d time=%0d:%0d:%0d",
                 kind, cyc, hours, minutes, seconds);
      end else begin
        e = sb.pop_front();
        al_bad = 1'b0;
`ifdef CLOCK_ALARM_EN
        al_bad = (alarm != e.al);
`endif
        if (e.kind != kind || e.cyc != cyc || int'(hours) != e.h || int'(minutes) != e.m ||
            int'(seconds) != e.s || valid !== 1'b1 || al_bad) begin
          errors++;
          $display("FAIL event kind=%0d cyc=%0d time=%0d:%0d:%0d valid=%0d alarm_bad=%0d required kind=%0d cyc=%0d time=%0d:%0d:%0d alarm=%0d",
                   kind, cyc, hours, minutes, seconds, valid, al_bad,
                   e.kind, e.cyc, e.h, e.m, e.s, e.al);
        end
      end
    end
`ifdef CLOCK_ALARM_EN
    if (alarm && !sec_tick) begin
      checks++;
      errors++;
      $display("FAIL alarm_without_tick cyc=%0d", cyc);
    end
`endif
    busy_q = busy;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic raise_finish(input logic [31:0] ut, output int n);
    @(posedge CLK);
    #1;
    userTime = ut;
    finish   = 1'b1;
    n        = cyc + 1;
  endtask

  task automatic drop_finish();
    @(posedge CLK);
    #1;
    finish = 1'b0;
  endtask

  // Busy must stay high until cycle k while the previous time is held on the outputs.
  task automatic check_window(input int k, input int oh, input int om, input int os, input int ov);
    int exp_p;
    exp_p = (oh << 13) | (om << 7) | (os << 1) | ov;
    forever begin
      @(negedge CLK);
      chk("busy_window", int'(busy), (cyc < k) ? 1 : 0);
      if (cyc >= k) break;
      chk("hold_outputs", int'({hours, minutes, seconds, valid}), exp_p);
    end
  endtask

  task automatic load_and_check(input logic [31:0] ut, input int h, input int m, input int s,
                                input int oh, input int om, input int os, input int ov,
                                output int k);
    int n;
    raise_finish(ut, n);
    k = n + h + m + 4;
    push(KIND_LOAD, k, h, m, s, 1'b0);
    drop_finish();
    check_window(k, oh, om, os, ov);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_time"}, int'({hours, minutes, seconds}), 0);
    chk({name, "_valid"}, int'(valid), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_tick"}, int'(sec_tick), 0);
`ifdef CLOCK_ALARM_EN
    chk({name, "_alarm"}, int'(alarm), 0);
`endif
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int k;
    int n;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_zero("reset");
    wait_cyc(cyc + 3 * int'(HZ) + 2);
    chk_zero("idle");

    load_and_check(32'd3661, 1, 1, 1, 0, 0, 0, 0, k);
    push(KIND_TICK, k + 4, 1, 1, 2, 1'b0);
    wait_cyc(k + 5);

    load_and_check(32'd86399, 23, 59, 59, 1, 1, 2, 1, k);
    push(KIND_TICK, k + 4, 0, 0, 0, 1'b0);
    push(KIND_TICK, k + 8, 0, 0, 1, 1'b0);
    wait_cyc(k + 9);
    pulse_reset();
    chk_zero("rst_run1");

    load_and_check(32'd88200, 0, 30, 0, 0, 0, 0, 0, k);
    push(KIND_TICK, k + 4, 0, 30, 1, 1'b0);
    wait_cyc(k + 5);

    load_and_check(32'd200000, 0, 0, 0, 0, 30, 1, 1, k);
    push(KIND_TICK, k + 4, 0, 0, 1, 1'b0);
    wait_cyc(k + 5);

    // Reload during CONV_H of a 23:00:00 conversion.
    raise_finish(32'd82800, n);
    drop_finish();
    wait_cyc(n + 3);
    userTime = 32'd60;
    finish   = 1'b1;
    k = n + 4 + 1 + 4;
    push(KIND_LOAD, k, 0, 1, 0, 1'b0);
    drop_finish();
    check_window(k, 0, 0, 1, 1);
    push(KIND_TICK, k + 4, 0, 1, 1, 1'b0);
    wait_cyc(k + 5);

    load_and_check(32'd25199, 6, 59, 59, 0, 1, 1, 1, k);
    push(KIND_TICK, k + 4, 7, 0, 0, 1'b1);
    push(KIND_TICK, k + 8, 7, 0, 1, 1'b0);
    wait_cyc(k + 9);

    load_and_check(32'd25200, 7, 0, 0, 7, 0, 1, 1, k);
    push(KIND_TICK, k + 4, 7, 0, 1, 1'b0);
    wait_cyc(k + 5);
    pulse_reset();
    chk_zero("rst_run2");

    wait_cyc(cyc + 3 * int'(HZ) + 2);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clock_keeper.md
# clock_keeper

Free-running time-of-day counter that consumes the seconds-since-midnight value and `finish` strobe produced by the time-setting stage. When `finish` rises, the block normalises the value and converts it to hours, minutes and seconds over several cycles with a subtract loop. It then advances the time once per second using a prescaler on `CLK`. Its hour, minute and second outputs feed the display/BCD stage.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: CLK cycles per second; prescaler terminal count is `CLK_HZ-1`. Must be ≥2.

Ports:
- `CLK`  in  1: system clock. Everything is rising-edge.
- `RST`  in  1: reset, synchronous, active-high.
- `userTime`  in  32: seconds since midnight from the setting stage. Legal range 0..172799.
- `finish`  in  1: level from the setting stage; each rising edge requests a load.
- `hours`  out  5: 0..23.
- `minutes`  out  6: 0..59.
- `seconds`  out  6: 0..59.
- `valid`  out  1: high once a time has been loaded; stays high until the next `RST`.
- `busy`  out  1: high while a load/conversion is in progress.
- `sec_tick`  out  1: one-cycle pulse on each second increment.
- `alarmH`  in  5: alarm hour. Present only with `CLOCK_ALARM_EN`.
- `alarmM`  in  6: alarm minute. Present only with `CLOCK_ALARM_EN`.
- `alarm`  out  1: one-cycle alarm pulse. Present only with `CLOCK_ALARM_EN`.

## Operation
- Edge detect: `finish_d` is registered every cycle. `load_req = finish & ~finish_d`. `finish_d` resets to 0, so `finish` held high through reset release produces a load on the first cycle after reset.
- FSM states are IDLE, LOAD, CONV_H, CONV_M, CONV_S and RUN. Reset state is IDLE.
- `load_req` in any state, including mid-conversion, forces LOAD on the next cycle. It has priority over every other transition.
- LOAD:
  - Captures `userTime` into 17-bit `rem`.
  - If `userTime` ≥ 86400, captures `userTime-86400` instead.
  - If `userTime` ≥ 172800, captures 0.
  - Clears the hour/minute accumulators and the prescaler, then goes to CONV_H.
- CONV_H: if `rem` ≥ 3600, `rem -= 3600` and hour accumulator +1, and stay. Otherwise go to CONV_M.
- CONV_M: if `rem` ≥ 60, `rem -= 60` and minute accumulator +1, and stay. Otherwise go to CONV_S.
- CONV_S: copies the accumulators to `hours`/`minutes`, copies `rem[5:0]` to `seconds`, sets `valid`, and goes to RUN.
  - The outputs update atomically here; they hold their old values during the whole conversion.
- RUN:
  - The prescaler counts 0..`CLK_HZ-1`. On the terminal count it wraps to 0, `sec_tick` pulses, and seconds increment.
  - Seconds 59→0 carries into minutes. Minutes 59→0 carries into hours. 23:59:59 → 00:00:00.
- IDLE: outputs hold 0 and the prescaler does not run.
- `busy` = state ∈ {LOAD, CONV_H, CONV_M, CONV_S}.

## Timing
- Reset values: `hours`=0, `minutes`=0, `seconds`=0, `valid`=0, `busy`=0, `sec_tick`=0, `alarm`=0. State is IDLE; prescaler and `rem` are 0.
- `RST` mid-conversion or mid-run returns the block to IDLE with reset values the next cycle. `RST` has priority over `load_req`.
- Load latency for a normalised value with h hours and m minutes:
  - `finish` rises at cycle N; LOAD is at N+1.
  - CONV_H lasts h+1 cycles and CONV_M lasts m+1 cycles.
  - CONV_S lasts 1 cycle; outputs are visible and `valid`=1 at cycle N+h+m+5.
  - `busy` is high for h+m+4 cycles. Worst case is 23:59:xx → 86 cycles.
- First `sec_tick` after entering RUN comes exactly `CLK_HZ` cycles after the CONV_S cycle.
- No ticks are counted during conversion; the time loss of up to 86 cycles is accepted.
- `finish` falling edge has no effect.

## Configuration
- Macro: `CLOCK_ALARM_EN`.
- Defined:
  - `alarmH`, `alarmM` and `alarm` exist.
  - `alarm` pulses for one cycle, coincident with `sec_tick`, when the increment results in `hours==alarmH`, `minutes==alarmM` and `seconds==0`.
  - A load that lands exactly on the alarm time does not fire.
  - Alarm input values outside 0..23 or 0..59 never match.
- Undefined: these ports and the compare logic are absent. All other behaviour is identical.

## Test plan
- Reset release with `finish`=0 and no further stimulus → all outputs 0, `busy`=0, no `sec_tick` for 3×`CLK_HZ` cycles.
- `userTime`=3661, `finish` 0→1 at cycle N → `busy` high N+1..N+6; at N+7 `hours`=1, `minutes`=1, `seconds`=1, `valid`=1.
- `CLK_HZ`=4, `userTime`=86399, load → 23:59:59; after 4 cycles, `sec_tick` pulses and the time reads 00:00:00.
- `userTime`=88200 → 00:30:00. `userTime`=200000 → 00:00:00 with `valid`=1.
- Second `finish` rising edge during CONV_H of a 23:00:00 load, with `userTime`=60 → conversion restarts and the result is 00:01:00; the old time stays on the outputs until CONV_S.
- With `CLOCK_ALARM_EN`, `CLK_HZ`=4, `alarmH`=7, `alarmM`=0, load 25199 (06:59:59) → `alarm` pulses exactly once, with the tick to 07:00:00. `RST` asserted mid-run → IDLE, zeros.
